// File: rtl/lcd_ctrl.sv
// LCD path sequencer: hands the single lcd_write port to lcd_init, then
// arbitrates it between the picture and character jobs with a stall watchdog.
module lcd_ctrl #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [8:0] init_data,
  input  logic       en_write_init,
  input  logic       init_done,
  output logic       wr_done_init,
  input  logic       pic_req,
  output logic       pic_start,
  input  logic [8:0] show_pic_data,
  input  logic       en_write_show_pic,
  input  logic       show_pic_done,
  output logic       wr_done_pic,
  input  logic       char_req,
  output logic       char_start,
  input  logic [8:0] show_char_data,
  input  logic       en_write_show_char,
  input  logic       show_char_done,
  output logic       wr_done_char,
  input  logic       wr_done,
  output logic [8:0] lcd_data,
  output logic       lcd_en_write,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] job_cnt
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_START, S_PIC, S_CHAR} state_t;

  state_t      state, state_next;
  logic        grant_pic, grant_pic_next;   // winner picked in IDLE
  logic        last_pic, last_pic_next;     // 1 = picture was served last
  logic [23:0] tmo_cnt, tmo_cnt_next;
  logic        timeout_err_next;
  logic [7:0]  job_cnt_next;
  logic [8:0]  lcd_data_next;
  logic        lcd_en_write_next;

  logic        has_owner;
  logic [8:0]  own_data;
  logic        own_en;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_INIT;
      grant_pic    <= 1'b0;
      last_pic     <= 1'b0;
      tmo_cnt      <= 24'd0;
      timeout_err  <= 1'b0;
      job_cnt      <= 8'd0;
      lcd_data     <= 9'h000;
      lcd_en_write <= 1'b0;
    end else begin
      state        <= state_next;
      grant_pic    <= grant_pic_next;
      last_pic     <= last_pic_next;
      tmo_cnt      <= tmo_cnt_next;
      timeout_err  <= timeout_err_next;
      job_cnt      <= job_cnt_next;
      lcd_data     <= lcd_data_next;
      lcd_en_write <= lcd_en_write_next;
    end
  end

  always_comb begin
    has_owner = 1'b0;
    own_data  = 9'h000;
    own_en    = 1'b0;
    case (state)
      S_INIT: begin has_owner = 1'b1; own_data = init_data;      own_en = en_write_init;      end
      S_PIC:  begin has_owner = 1'b1; own_data = show_pic_data;  own_en = en_write_show_pic;  end
      S_CHAR: begin has_owner = 1'b1; own_data = show_char_data; own_en = en_write_show_char; end
      default: ;
    endcase
  end

  always_comb begin
    state_next       = state;
    grant_pic_next   = grant_pic;
    last_pic_next    = last_pic;
    tmo_cnt_next     = 24'd0;
    timeout_err_next = timeout_err;
    job_cnt_next     = job_cnt;
    case (state)
      S_INIT: if (init_done) state_next = S_IDLE;
      S_IDLE: begin
        if (pic_req || char_req) begin
          // On a tie the side not served last wins.
          grant_pic_next   = pic_req && (!char_req || !last_pic);
          timeout_err_next = 1'b0;
          state_next       = S_START;
        end
      end
      S_START: state_next = grant_pic ? S_PIC : S_CHAR;
      S_PIC, S_CHAR: begin
        if (own_en || wr_done) tmo_cnt_next = 24'd0;
        else if (tmo_cnt != 24'hFF_FFFF) tmo_cnt_next = tmo_cnt + 24'd1;
        else tmo_cnt_next = tmo_cnt;
        if ((state == S_PIC) ? show_pic_done : show_char_done) begin
          state_next    = S_IDLE;
          job_cnt_next  = job_cnt + 8'd1;
          last_pic_next = (state == S_PIC);
        end else if (tmo_cnt >= TIMEOUT_CYC) begin
          state_next       = S_IDLE;
          timeout_err_next = 1'b1;
          last_pic_next    = (state == S_PIC);
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  // The strobe is suppressed on the owner's final cycle so it never leaks into IDLE.
  always_comb begin
    lcd_data_next     = has_owner ? own_data : lcd_data;
    lcd_en_write_next = has_owner && own_en && (state_next == state);
  end

  assign pic_start    = (state == S_START) && grant_pic;
  assign char_start   = (state == S_START) && !grant_pic;
  assign busy         = (state != S_IDLE);
  assign wr_done_init = wr_done && (state == S_INIT);
  assign wr_done_pic  = wr_done && (state == S_PIC);
  assign wr_done_char = wr_done && (state == S_CHAR);

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl: init routing, job routing, round-robin,
// watchdog timeout, done-vs-timeout priority and mid-job reset.
module tb_lcd_ctrl;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [8:0] init_data = 9'h000;
  logic       en_write_init = 1'b0, init_done = 1'b0, wr_done_init;
  logic       pic_req = 1'b0, pic_start;
  logic [8:0] show_pic_data = 9'h000;
  logic       en_write_show_pic = 1'b0, show_pic_done = 1'b0, wr_done_pic;
  logic       char_req = 1'b0, char_start;
  logic [8:0] show_char_data = 9'h000;
  logic       en_write_show_char = 1'b0, show_char_done = 1'b0, wr_done_char;
  logic       wr_done = 1'b0;
  logic [8:0] lcd_data;
  logic       lcd_en_write, busy, timeout_err;
  logic [7:0] job_cnt;
  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  lcd_ctrl #(.TIMEOUT_CYC(24'd100)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .init_data(init_data), .en_write_init(en_write_init), .init_done(init_done),
    .wr_done_init(wr_done_init),
    .pic_req(pic_req), .pic_start(pic_start), .show_pic_data(show_pic_data),
    .en_write_show_pic(en_write_show_pic), .show_pic_done(show_pic_done),
    .wr_done_pic(wr_done_pic),
    .char_req(char_req), .char_start(char_start), .show_char_data(show_char_data),
    .en_write_show_char(en_write_show_char), .show_char_done(show_char_done),
    .wr_done_char(wr_done_char),
    .wr_done(wr_done), .lcd_data(lcd_data), .lcd_en_write(lcd_en_write),
    .busy(busy), .timeout_err(timeout_err), .job_cnt(job_cnt)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_and_init();
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    tick(); tick();
    checks++; if (lcd_data !== 9'h000) begin errors++; $display("FAIL reset_lcd_data got=%h want=000", lcd_data); end
    checks++; if (lcd_en_write !== 1'b0) begin errors++; $display("FAIL reset_en got=%b want=0", lcd_en_write); end
    checks++; if ({pic_start, char_start} !== 2'b00) begin errors++; $display("FAIL reset_starts got=%b want=00", {pic_start, char_start}); end
    checks++; if ({wr_done_init, wr_done_pic, wr_done_char} !== 3'b000) begin errors++; $display("FAIL reset_wr_done got=%b want=000", {wr_done_init, wr_done_pic, wr_done_char}); end
    checks++; if ({busy, timeout_err, job_cnt} !== {1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL reset_status got=%b/%b/%0d want=1/0/0", busy, timeout_err, job_cnt); end
    $display("reset: busy=%b job_cnt=%0d", busy, job_cnt);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_init();
    for (int i = 0; i < 100; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL init_hold_busy got=%b want=1", busy); end
    init_data = 9'h011; en_write_init = 1'b1;
    tick();
    en_write_init = 1'b0;
    checks++; if ({lcd_en_write, lcd_data} !== {1'b1, 9'h011}) begin errors++; $display("FAIL init_route got=%b/%h want=1/011", lcd_en_write, lcd_data); end
    tick();
    checks++; if ({lcd_en_write, lcd_data} !== {1'b0, 9'h011}) begin errors++; $display("FAIL init_pulse_end got=%b/%h want=0/011", lcd_en_write, lcd_data); end
    wr_done = 1'b1; #1;
    checks++; if ({wr_done_init, wr_done_pic, wr_done_char} !== 3'b100) begin errors++; $display("FAIL init_wr_done got=%b want=100", {wr_done_init, wr_done_pic, wr_done_char}); end
    tick(); wr_done = 1'b0;
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_to_idle busy got=%b want=0", busy); end
    $display("init: lcd_data=%h busy=%b", lcd_data, busy);
  endtask

  task automatic test_pic_job();
    pic_req = 1'b1;
    tick();
    pic_req = 1'b0;
    checks++; if ({pic_start, char_start, lcd_en_write} !== 3'b100) begin errors++; $display("FAIL pic_start got=%b want=100", {pic_start, char_start, lcd_en_write}); end
    tick();
    checks++; if ({pic_start, busy} !== 2'b01) begin errors++; $display("FAIL pic_start_width got=%b want=01", {pic_start, busy}); end
    show_pic_data = 9'h12C; en_write_show_pic = 1'b1;
    show_char_data = 9'h1FF; en_write_show_char = 1'b1;
    tick();
    en_write_show_pic = 1'b0;
    checks++; if ({lcd_en_write, lcd_data} !== {1'b1, 9'h12C}) begin errors++; $display("FAIL pic_route got=%b/%h want=1/12c", lcd_en_write, lcd_data); end
    tick();
    checks++; if ({lcd_en_write, lcd_data} !== {1'b0, 9'h12C}) begin errors++; $display("FAIL pic_char_ignored got=%b/%h want=0/12c", lcd_en_write, lcd_data); end
    en_write_show_char = 1'b0;
    wr_done = 1'b1; #1;
    checks++; if ({wr_done_init, wr_done_pic, wr_done_char} !== 3'b010) begin errors++; $display("FAIL pic_wr_done got=%b want=010", {wr_done_init, wr_done_pic, wr_done_char}); end
    tick(); wr_done = 1'b0;
    show_pic_done = 1'b1;
    tick();
    show_pic_done = 1'b0;
    checks++; if ({busy, lcd_en_write, job_cnt} !== {1'b0, 1'b0, 8'd1}) begin errors++; $display("FAIL pic_done got=%b/%b/%0d want=0/0/1", busy, lcd_en_write, job_cnt); end
    wr_done = 1'b1; #1;
    checks++; if ({wr_done_init, wr_done_pic, wr_done_char} !== 3'b000) begin errors++; $display("FAIL idle_wr_done got=%b want=000", {wr_done_init, wr_done_pic, wr_done_char}); end
    tick(); wr_done = 1'b0;
    $display("pic job: job_cnt=%0d", job_cnt);
  endtask

  task automatic test_round_robin();
    logic exp_pic;
    reset_and_init();
    pic_req = 1'b1; char_req = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp_pic = (j % 2 == 0);
      tick();
      checks++; if ({pic_start, char_start} !== {exp_pic, !exp_pic}) begin errors++; $display("FAIL rr_grant job=%0d got=%b want=%b", j, {pic_start, char_start}, {exp_pic, !exp_pic}); end
      tick();
      show_pic_done = exp_pic; show_char_done = !exp_pic;
      tick();
      show_pic_done = 1'b0; show_char_done = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle job=%0d busy got=%b want=0", j, busy); end
      $display("rr job %0d: winner=%s job_cnt=%0d", j, exp_pic ? "PIC" : "CHAR", job_cnt);
    end
    pic_req = 1'b0; char_req = 1'b0;
    checks++; if (job_cnt !== 8'd4) begin errors++; $display("FAIL rr_job_cnt got=%0d want=4", job_cnt); end
  endtask

  task automatic test_timeout();
    pic_req = 1'b1;
    tick();
    pic_req = 1'b0;
    for (int i = 0; i < 101; i++) tick();
    checks++; if ({busy, timeout_err} !== 2'b10) begin errors++; $display("FAIL tmo_early got=%b want=10", {busy, timeout_err}); end
    tick();
    checks++; if ({busy, timeout_err, job_cnt} !== {1'b0, 1'b1, 8'd4}) begin errors++; $display("FAIL tmo_abort got=%b/%b/%0d want=0/1/4", busy, timeout_err, job_cnt); end
    $display("timeout: err=%b job_cnt=%0d", timeout_err, job_cnt);
  endtask

  task automatic test_done_at_timeout();
    pic_req = 1'b1;
    tick();
    pic_req = 1'b0;
    checks++; if ({pic_start, timeout_err} !== 2'b10) begin errors++; $display("FAIL tmo_clear_at_start got=%b want=10", {pic_start, timeout_err}); end
    for (int i = 0; i < 101; i++) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dat_still_busy got=%b want=1", busy); end
    show_pic_done = 1'b1;
    tick();
    show_pic_done = 1'b0;
    checks++; if ({busy, timeout_err, job_cnt} !== {1'b0, 1'b0, 8'd5}) begin errors++; $display("FAIL done_beats_tmo got=%b/%b/%0d want=0/0/5", busy, timeout_err, job_cnt); end
    $display("done at timeout: err=%b job_cnt=%0d", timeout_err, job_cnt);
  endtask

  task automatic test_reset_mid_job();
    pic_req = 1'b1;
    tick();
    pic_req = 1'b0;
    tick();
    show_pic_data = 9'h0AA; en_write_show_pic = 1'b1;
    tick();
    checks++; if ({lcd_en_write, lcd_data} !== {1'b1, 9'h0AA}) begin errors++; $display("FAIL mid_pre got=%b/%h want=1/0aa", lcd_en_write, lcd_data); end
    #2 sys_rst_n = 1'b0;
    #1;
    checks++; if ({lcd_en_write, lcd_data, busy, timeout_err, job_cnt} !== {1'b0, 9'h000, 1'b1, 1'b0, 8'd0}) begin errors++; $display("FAIL mid_reset got=%b/%h/%b/%b/%0d want=0/000/1/0/0", lcd_en_write, lcd_data, busy, timeout_err, job_cnt); end
    en_write_show_pic = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick(); tick();
    wr_done = 1'b1; #1;
    checks++; if ({busy, wr_done_init, wr_done_pic} !== 3'b110) begin errors++; $display("FAIL mid_back_in_init got=%b want=110", {busy, wr_done_init, wr_done_pic}); end
    wr_done = 1'b0;
    $display("reset mid job: busy=%b job_cnt=%0d", busy, job_cnt);
  endtask

  initial begin
    test_reset();
    test_init();
    test_pic_job();
    test_round_robin();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
